// File: rtl/md_unit_if.sv
// md_unit_if: request/response bundle between EX-stage control and md_unit.
//   master (EX side) drives : start, MDVop, cancel, A, B
//   slave  (md_unit) drives : busy, HI, LO, MDV_out
interface md_unit_if;
  logic        start;
  logic [3:0]  MDVop;
  logic        cancel;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDV_out;

  modport master (
    output start, MDVop, cancel, A, B,
    input  busy, HI, LO, MDV_out
  );

  modport slave (
    input  start, MDVop, cancel, A, B,
    output busy, HI, LO, MDV_out
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: multiply/divide responder for the EX stage; owns HI/LO.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : md_unit_if.slave
//           start/MDVop/cancel/A/B in; busy/HI/LO/MDV_out out
// mult/multu/div/divu compute their result on the accepting edge and hold
// it as pending; busy then runs for a fixed number of cycles and the
// pending value is committed to HI/LO on the last busy edge.
// mthi/mtlo write immediately; mfhi/mflo are a combinational read port.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no operation in flight, requests accepted
// RUN   | mult/div in flight, cnt_q counts down, commit at cnt_q == 1
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic        clk,
  input logic        reset,
  md_unit_if.slave   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MFHI  = 4'd4;
  localparam logic [3:0] OP_MFLO  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd6;
  localparam logic [3:0] OP_MTLO  = 4'd7;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;

  logic        busy_w;
  logic        req_ok;
  logic        accept;

  logic [63:0] prod_s, prod_u;
  logic [31:0] div_b;
  logic [31:0] a_mag, b_mag;
  logic [31:0] quot_mag, rem_mag;
  logic [31:0] quot_s, rem_s;
  logic [31:0] quot_u, rem_u;

  // Arithmetic datapath. Signed division is done on magnitudes so that
  // 0x80000000 / -1 wraps cleanly to 0x80000000 with remainder 0.
  // A zero divisor is replaced by 1 only to keep the dividers defined;
  // that result is never committed.
  always_comb begin
    prod_u   = {32'd0, bus.A} * {32'd0, bus.B};
    prod_s   = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    div_b    = (bus.B == 32'd0) ? 32'd1 : bus.B;
    a_mag    = bus.A[31] ? (32'd0 - bus.A) : bus.A;
    b_mag    = div_b[31] ? (32'd0 - div_b) : div_b;
    quot_mag = a_mag / b_mag;
    rem_mag  = a_mag % b_mag;
    quot_s   = (bus.A[31] ^ div_b[31]) ? (32'd0 - quot_mag) : quot_mag;
    rem_s    = bus.A[31] ? (32'd0 - rem_mag) : rem_mag;
    quot_u   = bus.A / div_b;
    rem_u    = bus.A % div_b;
  end

  assign busy_w = (state_q == RUN);
  assign req_ok = bus.start & ~bus.cancel & ~busy_w;
  assign accept = req_ok & (bus.MDVop <= OP_DIVU);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = RUN;
          cnt_d     = bus.MDVop[1] ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
          pend_wr_d = 1'b1;
          case (bus.MDVop)
            OP_MULT:  {pend_hi_d, pend_lo_d} = prod_s;
            OP_MULTU: {pend_hi_d, pend_lo_d} = prod_u;
            OP_DIV: begin
              pend_hi_d = rem_s;
              pend_lo_d = quot_s;
              pend_wr_d = (bus.B != 32'd0);
            end
            default: begin
              pend_hi_d = rem_u;
              pend_lo_d = quot_u;
              pend_wr_d = (bus.B != 32'd0);
            end
          endcase
        end else if (req_ok && bus.MDVop == OP_MTHI) begin
          hi_d = bus.A;
        end else if (req_ok && bus.MDVop == OP_MTLO) begin
          lo_d = bus.A;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign bus.busy    = busy_w;
  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;
  assign bus.MDV_out = (bus.MDVop == OP_MFHI) ? hi_q :
                       (bus.MDVop == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
module tb_md_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  md_unit_if mdv_if ();

  md_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mdv_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one request on the negedge; it is sampled at the following posedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic can);
    @(negedge clk);
    mdv_if.start  = 1'b1;
    mdv_if.MDVop  = op;
    mdv_if.A      = a;
    mdv_if.B      = b;
    mdv_if.cancel = can;
    @(posedge clk);
    #1;
    mdv_if.start  = 1'b0;
    mdv_if.cancel = 1'b0;
  endtask

  // Counts busy cycles from the next negedge on; returns at the first
  // negedge with busy low (or after the bound expires).
  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (mdv_if.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(op, a, b, 1'b0);
    wait_idle(n);
    check({tag, "_cycles"}, 32'(n), 32'(exp_n));
    check({tag, "_busy"}, {31'd0, mdv_if.busy}, 32'd0);
    check({tag, "_hi"}, mdv_if.HI, exp_hi);
    check({tag, "_lo"}, mdv_if.LO, exp_lo);
  endtask

  initial begin
    int n;
    n_checks      = 0;
    n_fails       = 0;
    reset         = 1'b1;
    mdv_if.start  = 1'b0;
    mdv_if.MDVop  = 4'd0;
    mdv_if.cancel = 1'b0;
    mdv_if.A      = 32'd0;
    mdv_if.B      = 32'd0;

    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, mdv_if.busy}, 32'd0);
    check("rst_hi", mdv_if.HI, 32'd0);
    check("rst_lo", mdv_if.LO, 32'd0);
    reset = 1'b0;

    // mult/multu
    run_op("mult", 4'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);

    // signed/unsigned divide
    run_op("div_m7_2", 4'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run_op("divu", 4'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    // mthi/mtlo then divide by zero
    issue(4'd6, 32'h1234_5678, 32'd0, 1'b0);
    @(negedge clk);
    check("mthi_busy", {31'd0, mdv_if.busy}, 32'd0);
    check("mthi_hi", mdv_if.HI, 32'h1234_5678);
    issue(4'd7, 32'hCAFE_F00D, 32'd0, 1'b0);
    @(negedge clk);
    check("mtlo_lo", mdv_if.LO, 32'hCAFE_F00D);
    run_op("divu_z", 4'd3, 32'd55, 32'd0, 10, 32'h1234_5678, 32'hCAFE_F00D);
    run_op("div_z", 4'd2, 32'hFFFF_FFF0, 32'd0, 10, 32'h1234_5678, 32'hCAFE_F00D);

    mdv_if.MDVop = 4'd4;
    #1;
    check("mfhi", mdv_if.MDV_out, 32'h1234_5678);
    mdv_if.MDVop = 4'd5;
    #1;
    check("mflo", mdv_if.MDV_out, 32'hCAFE_F00D);
    mdv_if.MDVop = 4'd0;
    #1;
    check("mdv_out_other", mdv_if.MDV_out, 32'd0);

    // cancelled and out-of-range requests leave everything untouched
    issue(4'd0, 32'd9, 32'd9, 1'b1);
    @(negedge clk);
    check("cancel_mult_busy", {31'd0, mdv_if.busy}, 32'd0);
    check("cancel_mult_lo", mdv_if.LO, 32'hCAFE_F00D);
    issue(4'd6, 32'hDEAD_BEEF, 32'd0, 1'b1);
    @(negedge clk);
    check("cancel_mthi_hi", mdv_if.HI, 32'h1234_5678);
    issue(4'd8, 32'hDEAD_BEEF, 32'd1, 1'b0);
    @(negedge clk);
    check("op8_busy", {31'd0, mdv_if.busy}, 32'd0);
    check("op8_hi", mdv_if.HI, 32'h1234_5678);

    // start during RUN is ignored; the original mult commits on time
    $display("note: start issued while busy on purpose (protocol error case)");
    issue(4'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    repeat (2) @(negedge clk);
    mdv_if.start = 1'b1;
    mdv_if.MDVop = 4'd3;
    mdv_if.A     = 32'd100;
    mdv_if.B     = 32'd7;
    @(posedge clk);
    #1;
    mdv_if.start = 1'b0;
    wait_idle(n);
    check("busy_blk_cycles", 32'(n + 2), 32'd5);
    check("busy_blk_hi", mdv_if.HI, 32'hFFFF_FFFF);
    check("busy_blk_lo", mdv_if.LO, 32'hFFFF_FFFA);

    // mthi on the commit edge is ignored
    issue(4'd1, 32'd2, 32'd3, 1'b0);
    repeat (5) @(negedge clk);
    check("commit_edge_busy", {31'd0, mdv_if.busy}, 32'd1);
    mdv_if.start = 1'b1;
    mdv_if.MDVop = 4'd6;
    mdv_if.A     = 32'h0000_0055;
    @(posedge clk);
    #1;
    mdv_if.start = 1'b0;
    @(negedge clk);
    check("commit_edge_idle", {31'd0, mdv_if.busy}, 32'd0);
    check("commit_edge_hi", mdv_if.HI, 32'd0);
    check("commit_edge_lo", mdv_if.LO, 32'd6);
    @(negedge clk);
    check("commit_edge_hi2", mdv_if.HI, 32'd0);

    // reset in cycle 4 of a mult aborts it
    issue(4'd6, 32'hA5A5_A5A5, 32'd0, 1'b0);
    issue(4'd0, 32'd5, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {31'd0, mdv_if.busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, mdv_if.busy}, 32'd0);
    check("mid_rst_hi", mdv_if.HI, 32'd0);
    check("mid_rst_lo", mdv_if.LO, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_busy", {31'd0, mdv_if.busy}, 32'd0);
    check("post_rst_hi", mdv_if.HI, 32'd0);
    check("post_rst_lo", mdv_if.LO, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
